// File: rtl/cfg_lock_sequencer.sv
// Purpose: programs a lockable config register, optionally verifies it by readback, then locks it.
// Latency: done SETTLE_CYCLES+3 edges after start (SETTLE_CYCLES+2 without readback); retry adds SETTLE_CYCLES+2.
// Backpressure: none; start sampled only in IDLE, scan_mode/debug_unlocked abort to a locked ERROR state.
// Optional feature: readback check compiled in when CFG_LOCK_READBACK_EN is defined.
module cfg_lock_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_RETRY     = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [15:0] cfg_data,
   input  logic        scan_mode,
   input  logic        debug_unlocked,
   input  logic [15:0] reg_rdata,
   output logic [15:0] reg_wdata,
   output logic        reg_write,
   output logic        reg_lock,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [1:0]  retry_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_SETTLE, S_CHECK, S_LOCK, S_DONE, S_ERROR
   } state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MODE_ST  = 2'b01;
   localparam logic [1:0] ERR_READBACK = 2'b10;
   localparam logic [1:0] ERR_MODE_MID = 2'b11;

   state_t      state_q, state_d;
   logic [15:0] wdata_q, wdata_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        lock_q, lock_d;
   logic [1:0]  code_q, code_d;
   logic        mode_block;
   logic        in_seq;

`ifdef CFG_LOCK_READBACK_EN
   localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);
   logic [1:0]  retry_q, retry_d;
`else
   // Readback path absent: these inputs/params intentionally have no load.
   localparam logic [1:0] UNUSED_RETRY_MAX = 2'(MAX_RETRY);
   logic        unused_rdata;
   assign unused_rdata = ^reg_rdata;
`endif

   assign mode_block = scan_mode | debug_unlocked;
   assign in_seq     = (state_q == S_WRITE) || (state_q == S_SETTLE) || (state_q == S_CHECK);

   // State and datapath registers; reset drops everything to a quiet IDLE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         wdata_q <= '0;
         cnt_q   <= '0;
         lock_q  <= 1'b0;
         code_q  <= ERR_NONE;
`ifdef CFG_LOCK_READBACK_EN
         retry_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
         code_q  <= code_d;
`ifdef CFG_LOCK_READBACK_EN
         retry_q <= retry_d;
`endif
      end
   end

   // Next-state logic; a test/debug mode abort mid-sequence overrides every other transition.
   always_comb begin
      state_d   = state_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      lock_d    = lock_q;
      code_d    = code_q;
      reg_write = 1'b0;
`ifdef CFG_LOCK_READBACK_EN
      retry_d   = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (mode_block) begin
                  state_d = S_ERROR;
                  code_d  = ERR_MODE_ST;
                  lock_d  = 1'b1;
               end else begin
                  state_d = S_WRITE;
                  wdata_d = cfg_data;
               end
            end
         end
         S_WRITE: begin
            // Strobe is gated combinationally so a mode change never leaks a write.
            reg_write = ~mode_block;
            state_d   = S_SETTLE;
            cnt_d     = SETTLE_LD;
         end
         S_SETTLE: begin
            if (cnt_q <= 4'd1) begin
               cnt_d = '0;
`ifdef CFG_LOCK_READBACK_EN
               state_d = S_CHECK;
`else
               state_d = S_LOCK;
               lock_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`ifdef CFG_LOCK_READBACK_EN
         S_CHECK: begin
            if (reg_rdata == wdata_q) begin
               state_d = S_LOCK;
               lock_d  = 1'b1;
            end else if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 2'd1;
               state_d = S_WRITE;
            end else begin
               state_d = S_ERROR;
               code_d  = ERR_READBACK;
               lock_d  = 1'b1;
            end
         end
`endif
         S_LOCK:  state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         S_ERROR: state_d = S_ERROR;
         default: begin
            // Unreachable encodings fail secure.
            state_d = S_ERROR;
            code_d  = ERR_MODE_MID;
            lock_d  = 1'b1;
         end
      endcase

      if (in_seq && mode_block) begin
         state_d = S_ERROR;
         code_d  = ERR_MODE_MID;
         lock_d  = 1'b1;
      end
   end

   assign reg_wdata = wdata_q;
   assign reg_lock  = lock_q;
   assign busy      = in_seq;
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_ERROR);
   assign err_code  = code_q;
`ifdef CFG_LOCK_READBACK_EN
   assign retry_cnt = retry_q;
`else
   assign retry_cnt = 2'd0;
`endif

endmodule

// File: tb/tb_cfg_lock_sequencer.sv
// Bench for cfg_lock_sequencer at default parameters (SETTLE_CYCLES=2, MAX_RETRY=3).
// Table of start/readback scenarios plus hand-written abort, reset and gating sequences.
// Expectations follow the build: CFG_LOCK_READBACK_EN selects the readback timing/results.
module tb_cfg_lock_sequencer;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [15:0] cfg_data;
   logic        scan_mode;
   logic        debug_unlocked;
   logic [15:0] reg_rdata;
   logic [15:0] reg_wdata;
   logic        reg_write;
   logic        reg_lock;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;
   logic [1:0]  retry_cnt;

   logic        rd_echo;
   logic [15:0] rd_fixed;

`ifdef CFG_LOCK_READBACK_EN
   localparam int LAT_OK = 5;
`else
   localparam int LAT_OK = 4;
`endif

   cfg_lock_sequencer dut (
      .clk            (clk),
      .resetn         (resetn),
      .start          (start),
      .cfg_data       (cfg_data),
      .scan_mode      (scan_mode),
      .debug_unlocked (debug_unlocked),
      .reg_rdata      (reg_rdata),
      .reg_wdata      (reg_wdata),
      .reg_write      (reg_write),
      .reg_lock       (reg_lock),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .err_code       (err_code),
      .retry_cnt      (retry_cnt)
   );

   // Register model: either echoes what was written or returns a stuck value.
   assign reg_rdata = rd_echo ? reg_wdata : rd_fixed;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int wr_cnt   = 0;
   bit both_seen = 1'b0;

   // Each WRITE state spans exactly one negedge, so this counts strobes.
   always @(negedge clk) begin
      if (reg_write) wr_cnt <= wr_cnt + 1;
      if (done && error) both_seen <= 1'b1;
   end

   typedef struct {
      logic [15:0] cfg;
      logic        echo;
      logic [15:0] fixed;
      logic        scan;
      logic        dbg;
      logic        exp_done;
      logic        exp_err;
      logic [1:0]  exp_code;
      logic [1:0]  exp_retry;
      int          exp_wr;
      int          exp_lat;
      logic [15:0] exp_wdata;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      resetn         = 1'b0;
      start          = 1'b0;
      scan_mode      = 1'b0;
      debug_unlocked = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   // Wait up to a bound for done or error; returns edges waited.
   task automatic wait_term(output int k);
      k = 0;
      while (!(done || error) && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   int k;
   int base;
   int wr_snap;

   initial begin
`ifdef CFG_LOCK_READBACK_EN
      vecs[0] = '{16'hA5C3, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1, LAT_OK, 16'hA5C3};
      vecs[1] = '{16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 4, 16,     16'h1234};
      vecs[4] = '{16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 4, 16,     16'h0001};
`else
      vecs[0] = '{16'hA5C3, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1, LAT_OK, 16'hA5C3};
      vecs[1] = '{16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1, LAT_OK, 16'h1234};
      vecs[4] = '{16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1, LAT_OK, 16'h0001};
`endif
      vecs[2] = '{16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 0, 0, 16'h0000};
      vecs[3] = '{16'h0F0F, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 0, 0, 16'h0000};

      rd_echo        = 1'b1;
      rd_fixed       = 16'h0000;
      cfg_data       = 16'h0000;
      start          = 1'b0;
      scan_mode      = 1'b0;
      debug_unlocked = 1'b0;
      resetn         = 1'b0;
      #2;
      chk("reset_outputs",
          {9'd0, reg_wdata, reg_write, reg_lock, busy, done, error, err_code, retry_cnt}, 32'd0);

      // Table-driven scenarios.
      for (int i = 0; i < 5; i++) begin
         do_reset();
         rd_echo        = vecs[i].echo;
         rd_fixed       = vecs[i].fixed;
         cfg_data       = vecs[i].cfg;
         scan_mode      = vecs[i].scan;
         debug_unlocked = vecs[i].dbg;
         start          = 1'b1;
         base           = wr_cnt;
         @(posedge clk);
         #1;
         start          = 1'b0;
         scan_mode      = 1'b0;
         debug_unlocked = 1'b0;
         wait_term(k);
         chk($sformatf("v%0d_latency", i), k, vecs[i].exp_lat);
         chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
         chk($sformatf("v%0d_error", i), error, vecs[i].exp_err);
         chk($sformatf("v%0d_err_code", i), err_code, vecs[i].exp_code);
         chk($sformatf("v%0d_retry_cnt", i), retry_cnt, vecs[i].exp_retry);
         chk($sformatf("v%0d_reg_lock", i), reg_lock, 1'b1);
         chk($sformatf("v%0d_busy", i), busy, 1'b0);
         chk($sformatf("v%0d_reg_wdata", i), reg_wdata, vecs[i].exp_wdata);
         chk($sformatf("v%0d_writes", i), wr_cnt - base, vecs[i].exp_wr);
         // Terminal states ignore start.
         @(negedge clk);
         wr_snap  = wr_cnt;
         cfg_data = 16'hDEAD;
         start    = 1'b1;
         repeat (3) @(negedge clk);
         start = 1'b0;
         chk($sformatf("v%0d_terminal", i),
             {reg_wdata, done, error, err_code, 4'(wr_cnt - wr_snap)},
             {vecs[i].exp_wdata, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_code, 4'd0});
      end

      // debug_unlocked rises during SETTLE.
      do_reset();
      rd_echo  = 1'b1;
      cfg_data = 16'h3C3C;
      start    = 1'b1;
      base     = wr_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("dbg_settle_busy", busy, 1'b1);
      debug_unlocked = 1'b1;
      @(posedge clk); #1;
      chk("dbg_settle_error", {error, err_code, reg_lock, done}, {1'b1, 2'd3, 1'b1, 1'b0});
      repeat (4) @(posedge clk);
      #1;
      chk("dbg_settle_after", {done, error, err_code, 4'(wr_cnt - base)}, {1'b0, 1'b1, 2'd3, 4'd1});
      debug_unlocked = 1'b0;

      // scan_mode rises while in WRITE: strobe gated, abort next edge.
      do_reset();
      cfg_data = 16'h7777;
      start    = 1'b1;
      base     = wr_cnt;
      @(posedge clk); #1;
      start     = 1'b0;
      scan_mode = 1'b1;
      #1;
      chk("scan_write_gated", reg_write, 1'b0);
      @(posedge clk); #1;
      chk("scan_write_abort", {error, err_code, reg_lock, 4'(wr_cnt - base)}, {1'b1, 2'd3, 1'b1, 4'd0});
      scan_mode = 1'b0;

      // Reset pulsed mid-SETTLE, then a fresh sequence.
      do_reset();
      cfg_data = 16'h1111;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      resetn = 1'b0;
      #1;
      chk("midreset_outputs",
          {9'd0, reg_wdata, reg_write, reg_lock, busy, done, error, err_code, retry_cnt}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      base   = wr_cnt;
      repeat (4) @(negedge clk);
      chk("midreset_idle", {busy, reg_lock, done, error, 4'(wr_cnt - base)}, 8'd0);
      cfg_data = 16'hBEEF;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_term(k);
      chk("beef_latency", k, LAT_OK);
      chk("beef_result", {reg_wdata, done, error, reg_lock, 4'(wr_cnt - base)},
          {16'hBEEF, 1'b1, 1'b0, 1'b1, 4'd1});

      chk("done_error_exclusive", both_seen, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
